parity_frame_checker: RTL and testbench

//   Frame-level parity checker downstream of the XOR parity-generation stage.
//   - Accepts data words, each carrying the parity bit computed upstream.
//   - Re-checks every word's parity and accumulates a column XOR across FRAME_LEN words.
//   - Reports one result per frame (column parity, bad-word count, error flag) over a valid/ready handshake.

---
 rtl/parity_pkg.sv | 15 +
 rtl/parity_word_check.sv | 13 +
 rtl/parity_frame_checker.sv | 135 +++++++++++++
 tb/tb_parity_frame_checker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and helpers for the frame-level parity checker.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } pfc_state_t;

    // Width needed to count 0..frame_len bad words inclusive.
    function automatic int cnt_w(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/parity_word_check.sv
// Combinational re-check of one word against the parity bit produced upstream.
module parity_word_check #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic [DATA_W-1:0] data,
    input  logic              par,
    output logic              word_err
);

    assign word_err = par ^ (^data) ^ ODD_PARITY;

endmodule

// File: rtl/parity_frame_checker.sv
// Accumulates column parity and bad-word count over FRAME_LEN words and
// presents one result per frame on a valid/ready handshake.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FRAME_LEN  = 4,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_par,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_frame_par,
    output logic [cnt_w(FRAME_LEN)-1:0]  out_err_cnt,
    output logic                         out_err
);

    localparam int CNT_W = cnt_w(FRAME_LEN);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    pfc_state_t         state, next_state;
    logic [IDX_W-1:0]   word_idx;
    logic [DATA_W-1:0]  acc_par;
    logic [CNT_W-1:0]   acc_cnt;

    logic               word_err;
    logic               accept;
    logic               last_accept;
    logic [DATA_W-1:0]  frame_par_next;
    logic [CNT_W-1:0]   err_cnt_next;

    parity_word_check #(
        .DATA_W     (DATA_W),
        .ODD_PARITY (ODD_PARITY)
    ) u_word_check (
        .data     (in_data),
        .par      (in_par),
        .word_err (word_err)
    );

    assign frame_par_next = acc_par ^ in_data;
    assign err_cnt_next   = acc_cnt + CNT_W'(word_err);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a signal unassigned (latch).
    always_comb begin
        next_state  = state;
        in_ready    = (state != HOLD);
        out_valid   = (state == HOLD);
        // A word offered during flush is dropped, so flush masks the accept.
        accept      = in_valid && in_ready && !flush;
        last_accept = accept && (word_idx == LAST_IDX);

        case (state)
            IDLE: begin
                if (accept) next_state = ACCUM;
            end
            ACCUM: begin
                if (flush)            next_state = IDLE;
                else if (last_accept) next_state = HOLD;
            end
            HOLD: begin
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Word counter and running accumulators; flush in HOLD falls into the
    // HOLD branch and is therefore ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx <= '0;
            acc_par  <= '0;
            acc_cnt  <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (flush) begin
                        word_idx <= '0;
                        acc_par  <= '0;
                        acc_cnt  <= '0;
                    end else if (accept && !last_accept) begin
                        word_idx <= word_idx + 1'b1;
                        acc_par  <= frame_par_next;
                        acc_cnt  <= err_cnt_next;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        word_idx <= '0;
                        acc_par  <= '0;
                        acc_cnt  <= '0;
                    end
                end
                default: begin
                    word_idx <= '0;
                    acc_par  <= '0;
                    acc_cnt  <= '0;
                end
            endcase
        end
    end

    // Result registers load only on the edge that accepts the final word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_frame_par <= '0;
            out_err_cnt   <= '0;
            out_err       <= 1'b0;
        end else if (last_accept) begin
            out_frame_par <= frame_par_next;
            out_err_cnt   <= err_cnt_next;
            out_err       <= (err_cnt_next != '0);
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed self-checking bench for parity_frame_checker (DATA_W=8, FRAME_LEN=4, even parity).
module tb_parity_frame_checker;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_par;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_frame_par;
    logic [2:0] out_err_cnt;
    logic       out_err;

    int tests = 0;
    int fails = 0;

    parity_frame_checker #(
        .DATA_W     (8),
        .FRAME_LEN  (4),
        .ODD_PARITY (1'b0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_par        (in_par),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_frame_par (out_frame_par),
        .out_err_cnt   (out_err_cnt),
        .out_err       (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered and left on a negedge; the word transfers on the posedge between.
    task automatic send(input logic [7:0] d, input logic p);
        in_valid = 1'b1;
        in_data  = d;
        in_par   = p;
        check("send_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] par, input logic [2:0] cnt);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_par"}, 32'(out_frame_par), 32'(par));
        check({tag, "_cnt"}, 32'(out_err_cnt), 32'(cnt));
        check({tag, "_err"}, 32'(out_err), 32'(cnt != 3'd0));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Standard clean frame: 0x01^0x03^0x07^0x0F = 0x0A, even parity bits 1,0,1,0.
    task automatic send_clean_frame();
        send(8'h01, 1'b1);
        send(8'h03, 1'b0);
        send(8'h07, 1'b1);
        check("pre_last_valid", 32'(out_valid), 32'd0);
        send(8'h0F, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_par    = 1'b0;
        out_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_frame_par", 32'(out_frame_par), 32'd0);
        check("rst_err_cnt", 32'(out_err_cnt), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);

        // Test 1: reset mid-frame discards two accepted words
        send(8'hAA, 1'b1);
        send(8'h55, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        send_clean_frame();
        check_result("t1", 8'h0A, 3'd0);
        consume("t1");

        // Test 2: clean frame
        send_clean_frame();
        check_result("t2", 8'h0A, 3'd0);
        consume("t2");

        // Test 3: third word (0x07) with its parity bit flipped
        send(8'h01, 1'b1);
        send(8'h03, 1'b0);
        send(8'h07, 1'b0);
        send(8'h0F, 1'b0);
        check_result("t3", 8'h0A, 3'd1);
        consume("t3");

        // Every word bad: count reaches FRAME_LEN without wrapping
        send(8'h01, 1'b0);
        send(8'h03, 1'b1);
        send(8'h07, 1'b0);
        send(8'h0F, 1'b1);
        check_result("all_bad", 8'h0A, 3'd4);
        consume("all_bad");

        // Test 4: backpressure for 5 cycles, with a word offered during HOLD
        send_clean_frame();
        in_valid = 1'b1;
        in_data  = 8'hC3;
        in_par   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_result("t4_hold", 8'h0A, 3'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        consume("t4");
        check("t4_fields_kept", 32'(out_frame_par), 32'h0A);

        // Test 5: flush after two words drops the partial frame and the word offered with it
        send(8'h01, 1'b1);
        send(8'h03, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_par   = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t5_flush_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            send(8'hFF, 1'b0);
            check("t5_not_done", 32'(out_valid), 32'd0);
        end
        send(8'hFF, 1'b0);
        check_result("t5", 8'h00, 3'd0);
        flush = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b0;
        check_result("t5_hold_flush", 8'h00, 3'd0);
        consume("t5");

        // Test 6: clean frame with random idle gaps between words
        begin
            logic [7:0] words [4];
            logic       pars  [4];
            words = '{8'h01, 8'h03, 8'h07, 8'h0F};
            pars  = '{1'b1, 1'b0, 1'b1, 1'b0};
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(words[i], pars[i]);
            end
        end
        begin
            int budget = 0;
            while (!out_valid && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            check("t6_valid_timeout", 32'(out_valid), 32'd1);
        end
        check_result("t6", 8'h0A, 3'd0);
        consume("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
